// File: rtl/usb3_rx_framer.sv
// USB3 link-layer receive framer: finds HPSTART/DPPSTART/DPPEND/DPPABORT framing in the
// descrambled word stream, extracts header packets and data payloads, and flags framing errors.
module usb3_rx_framer #(
    parameter int MAX_DPP_WORDS = 257,
    parameter int DPP_WAIT      = 4,
    parameter int GAP_TIMEOUT   = 8
) (
    input  logic        local_clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_active,
    output logic [95:0] hp_header,
    output logic [31:0] hp_lcw,
    output logic        hp_valid,
    output logic [31:0] dpp_data,
    output logic        dpp_valid,
    output logic        dpp_start,
    output logic        dpp_end,
    output logic        dpp_abort,
    output logic [8:0]  dpp_words,
    output logic        err_frame
);
    // in_active qualifies each input word (no backpressure); every strobe and valid output is
    // registered and high for exactly one local_clk cycle, one cycle after the consuming edge.

    localparam int WAIT_W = $clog2(DPP_WAIT + 1);
    localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);

    localparam logic [31:0] HPSTART  = 32'hFBFBFBF7;
    localparam logic [31:0] DPPSTART = 32'h5C5C5CF7;
    localparam logic [31:0] DPPEND   = 32'hFDFDFDF7;
    localparam logic [31:0] DPPABORT = 32'h7C7C7CF7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR      = 2'd1,
        WAIT_DPP = 2'd2,
        DPP      = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [1:0]          hdr_cnt, hdr_cnt_nx;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_nx;
    logic [95:0]         hdr_buf, hdr_buf_nx;

    logic [95:0] hp_header_nx;
    logic [31:0] hp_lcw_nx, dpp_data_nx;
    logic [8:0]  dpp_words_nx;
    logic        hp_valid_nx, dpp_valid_nx, dpp_start_nx, dpp_end_nx, dpp_abort_nx, err_frame_nx;

    logic is_data, is_hp, is_dps, is_dpe, is_dpa;

    assign is_data = (in_datak == 4'b0000);
    assign is_hp   = (in_datak == 4'b1111) && (in_data == HPSTART);
    assign is_dps  = (in_datak == 4'b1111) && (in_data == DPPSTART);
    assign is_dpe  = (in_datak == 4'b1111) && (in_data == DPPEND);
    assign is_dpa  = (in_datak == 4'b1111) && (in_data == DPPABORT);

    always_ff @(posedge local_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hdr_cnt_nx   = hdr_cnt;
        wait_cnt_nx  = wait_cnt;
        gap_cnt_nx   = gap_cnt;
        hdr_buf_nx   = hdr_buf;
        hp_header_nx = hp_header;
        hp_lcw_nx    = hp_lcw;
        dpp_data_nx  = dpp_data;
        dpp_words_nx = dpp_words;
        hp_valid_nx  = 1'b0;
        dpp_valid_nx = 1'b0;
        dpp_start_nx = 1'b0;
        dpp_end_nx   = 1'b0;
        dpp_abort_nx = 1'b0;
        err_frame_nx = 1'b0;

        if (!in_active) begin
            if (gap_cnt != GAP_W'(GAP_TIMEOUT)) begin
                gap_cnt_nx = gap_cnt + 1'b1;
            end
            // Only open packets time out; IDLE and WAIT_DPP just let the counter saturate.
            if ((state == HDR || state == DPP) && gap_cnt_nx == GAP_W'(GAP_TIMEOUT)) begin
                err_frame_nx = 1'b1;
                dpp_abort_nx = (state == DPP);
                state_nx     = IDLE;
            end
        end else begin
            gap_cnt_nx = '0;
            unique case (state)
                IDLE: begin
                    if (is_hp) begin
                        state_nx   = HDR;
                        hdr_cnt_nx = 2'd0;
                    end
                end
                HDR: begin
                    if (is_data) begin
                        if (hdr_cnt == 2'd3) begin
                            hp_header_nx = hdr_buf;
                            hp_lcw_nx    = in_data;
                            hp_valid_nx  = 1'b1;
                            hdr_cnt_nx   = 2'd0;
                            wait_cnt_nx  = '0;
                            state_nx     = WAIT_DPP;
                        end else begin
                            case (hdr_cnt)
                                2'd0:    hdr_buf_nx[95:64] = in_data;
                                2'd1:    hdr_buf_nx[63:32] = in_data;
                                default: hdr_buf_nx[31:0]  = in_data;
                            endcase
                            hdr_cnt_nx = hdr_cnt + 2'd1;
                        end
                    end else if (is_hp) begin
                        err_frame_nx = 1'b1;
                        hdr_cnt_nx   = 2'd0;
                    end else begin
                        err_frame_nx = 1'b1;
                        hdr_cnt_nx   = 2'd0;
                        state_nx     = IDLE;
                    end
                end
                WAIT_DPP: begin
                    if (is_dps) begin
                        dpp_words_nx = 9'd0;
                        state_nx     = DPP;
                    end else if (is_hp) begin
                        hdr_cnt_nx = 2'd0;
                        state_nx   = HDR;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                        if (wait_cnt_nx == WAIT_W'(DPP_WAIT)) begin
                            state_nx = IDLE;
                        end
                    end
                end
                DPP: begin
                    if (is_data) begin
                        if (dpp_words == 9'(MAX_DPP_WORDS)) begin
                            err_frame_nx = 1'b1;
                            dpp_abort_nx = 1'b1;
                            state_nx     = IDLE;
                        end else begin
                            dpp_valid_nx = 1'b1;
                            dpp_start_nx = (dpp_words == 9'd0);
                            dpp_data_nx  = in_data;
                            if (dpp_words != 9'h1FF) begin
                                dpp_words_nx = dpp_words + 9'd1;
                            end
                        end
                    end else if (is_dpe) begin
                        dpp_end_nx   = 1'b1;
                        err_frame_nx = (dpp_words == 9'd0);
                        state_nx     = IDLE;
                    end else if (is_dpa) begin
                        dpp_abort_nx = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        err_frame_nx = 1'b1;
                        dpp_abort_nx = 1'b1;
                        state_nx     = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge local_clk) begin
        if (reset) begin
            hdr_cnt   <= 2'd0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            hdr_buf   <= '0;
            hp_header <= '0;
            hp_lcw    <= '0;
            dpp_data  <= '0;
            dpp_words <= '0;
            hp_valid  <= 1'b0;
            dpp_valid <= 1'b0;
            dpp_start <= 1'b0;
            dpp_end   <= 1'b0;
            dpp_abort <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            hdr_cnt   <= hdr_cnt_nx;
            wait_cnt  <= wait_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            hdr_buf   <= hdr_buf_nx;
            hp_header <= hp_header_nx;
            hp_lcw    <= hp_lcw_nx;
            dpp_data  <= dpp_data_nx;
            dpp_words <= dpp_words_nx;
            hp_valid  <= hp_valid_nx;
            dpp_valid <= dpp_valid_nx;
            dpp_start <= dpp_start_nx;
            dpp_end   <= dpp_end_nx;
            dpp_abort <= dpp_abort_nx;
            err_frame <= err_frame_nx;
        end
    end

endmodule

// File: tb/tb_usb3_rx_framer.sv
// Bench for usb3_rx_framer: directed framing scenarios plus randomized packet streams,
// compared against a packet-level reference model through a timestamped expected-event queue.
module tb_usb3_rx_framer;
    localparam int MAX_DPP_WORDS = 257;
    localparam int DPP_WAIT      = 4;
    localparam int GAP_TIMEOUT   = 8;

    localparam logic [31:0] HP  = 32'hFBFBFBF7;
    localparam logic [31:0] DPS = 32'h5C5C5CF7;
    localparam logic [31:0] DPE = 32'hFDFDFDF7;
    localparam logic [31:0] DPA = 32'h7C7C7CF7;

    logic        local_clk = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] in_data   = '0;
    logic [3:0]  in_datak  = '0;
    logic        in_active = 1'b0;
    logic [95:0] hp_header;
    logic [31:0] hp_lcw, dpp_data;
    logic        hp_valid, dpp_valid, dpp_start, dpp_end, dpp_abort, err_frame;
    logic [8:0]  dpp_words;

    usb3_rx_framer #(
        .MAX_DPP_WORDS(MAX_DPP_WORDS),
        .DPP_WAIT(DPP_WAIT),
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) dut (
        .local_clk(local_clk),
        .reset(reset),
        .in_data(in_data),
        .in_datak(in_datak),
        .in_active(in_active),
        .hp_header(hp_header),
        .hp_lcw(hp_lcw),
        .hp_valid(hp_valid),
        .dpp_data(dpp_data),
        .dpp_valid(dpp_valid),
        .dpp_start(dpp_start),
        .dpp_end(dpp_end),
        .dpp_abort(dpp_abort),
        .dpp_words(dpp_words),
        .err_frame(err_frame)
    );

    // ---------------- clock / reset ----------------
    always #5 local_clk = ~local_clk;

    int cyc = 0;
    always @(posedge local_clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] stamp;
        logic [5:0]  strb;   // {hp_valid, dpp_valid, dpp_start, dpp_end, dpp_abort, err_frame}
        logic [95:0] hdr;
        logic [31:0] lcw;
        logic [31:0] data;
        logic [8:0]  words;
    } ev_t;
    localparam int EV_W = $bits(ev_t);

    logic [EV_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    ev_t mon_got, mon_exp;
    always @(negedge local_clk) begin
        if (hp_valid | dpp_valid | dpp_start | dpp_end | dpp_abort | err_frame) begin
            mon_got.stamp = cyc;
            mon_got.strb  = {hp_valid, dpp_valid, dpp_start, dpp_end, dpp_abort, err_frame};
            mon_got.hdr   = hp_header;
            mon_got.lcw   = hp_lcw;
            mon_got.data  = dpp_data;
            mon_got.words = dpp_words;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d strb=%b data=%h words=%0d",
                         cyc, mon_got.strb, dpp_data, dpp_words);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event got: cyc=%0d strb=%b hdr=%h lcw=%h data=%h words=%0d | required: cyc=%0d strb=%b hdr=%h lcw=%h data=%h words=%0d",
                             mon_got.stamp, mon_got.strb, mon_got.hdr, mon_got.lcw, mon_got.data, mon_got.words,
                             mon_exp.stamp, mon_exp.strb, mon_exp.hdr, mon_exp.lcw, mon_exp.data, mon_exp.words);
                end
            end
        end
    end

    // ---------------- reference model (packet level) ----------------
    bit          m_in_hdr, m_in_dpp;
    int          m_wait_left, m_gap, m_dpp_n;
    logic [31:0] m_hq[$];
    logic [95:0] m_hdr;
    logic [31:0] m_lcw, m_data;
    logic [8:0]  m_words;

    task automatic model_reset();
        m_in_hdr = 0; m_in_dpp = 0;
        m_wait_left = 0; m_gap = 0; m_dpp_n = 0;
        m_hq.delete();
        m_hdr = '0; m_lcw = '0; m_data = '0; m_words = '0;
    endtask

    task automatic model_step(input logic act, input logic [31:0] d, input logic [3:0] k, input int stamp);
        logic hv = 0, dv = 0, ds = 0, de = 0, da = 0, er = 0;
        bit is_data, is_hp, is_dps, is_dpe, is_dpa;
        ev_t e;
        is_data = (k == 4'h0);
        is_hp   = (k == 4'hF) && (d == HP);
        is_dps  = (k == 4'hF) && (d == DPS);
        is_dpe  = (k == 4'hF) && (d == DPE);
        is_dpa  = (k == 4'hF) && (d == DPA);
        if (!act) begin
            m_gap++;
            if (m_gap == GAP_TIMEOUT && (m_in_hdr || m_in_dpp)) begin
                er = 1; da = m_in_dpp;
                m_in_hdr = 0; m_in_dpp = 0; m_hq.delete();
            end
        end else begin
            m_gap = 0;
            if (m_in_hdr) begin
                if (is_data) begin
                    m_hq.push_back(d);
                    if (m_hq.size() == 4) begin
                        hv = 1;
                        m_hdr = {m_hq[0], m_hq[1], m_hq[2]};
                        m_lcw = m_hq[3];
                        m_hq.delete();
                        m_in_hdr = 0;
                        m_wait_left = DPP_WAIT;
                    end
                end else if (is_hp) begin
                    er = 1; m_hq.delete();
                end else begin
                    er = 1; m_hq.delete(); m_in_hdr = 0;
                end
            end else if (m_in_dpp) begin
                if (is_data) begin
                    if (m_dpp_n >= MAX_DPP_WORDS) begin
                        er = 1; da = 1; m_in_dpp = 0;
                    end else begin
                        dv = 1; ds = (m_dpp_n == 0);
                        m_data = d;
                        m_dpp_n = (m_dpp_n < 511) ? m_dpp_n + 1 : 511;
                        m_words = 9'(m_dpp_n);
                    end
                end else if (is_dpe) begin
                    de = 1; er = (m_dpp_n == 0); m_in_dpp = 0;
                end else if (is_dpa) begin
                    da = 1; m_in_dpp = 0;
                end else begin
                    er = 1; da = 1; m_in_dpp = 0;
                end
            end else if (m_wait_left > 0) begin
                if (is_dps) begin
                    m_in_dpp = 1; m_dpp_n = 0; m_words = '0; m_wait_left = 0;
                end else if (is_hp) begin
                    m_in_hdr = 1; m_hq.delete(); m_wait_left = 0;
                end else begin
                    m_wait_left--;
                end
            end else if (is_hp) begin
                m_in_hdr = 1; m_hq.delete();
            end
        end
        if (hv | dv | ds | de | da | er) begin
            e.stamp = stamp;
            e.strb  = {hv, dv, ds, de, da, er};
            e.hdr   = m_hdr;
            e.lcw   = m_lcw;
            e.data  = m_data;
            e.words = m_words;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic act, input logic [31:0] d, input logic [3:0] k);
        @(negedge local_clk);
        in_active = act;
        in_data   = d;
        in_datak  = k;
        model_step(act, d, k, cyc + 1);
    endtask

    task automatic word(input logic [31:0] d);
        drive(1'b1, d, 4'h0);
    endtask

    task automatic kw(input logic [31:0] d);
        drive(1'b1, d, 4'hF);
    endtask

    task automatic noise();
        drive(1'b1, $urandom(), 4'($urandom_range(1, 15)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom(), 4'($urandom_range(0, 15)));
    endtask

    task automatic maybe_gap();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) idle(1);
        else if (r == 2) idle($urandom_range(2, GAP_TIMEOUT - 1));
    endtask

    task automatic send_hdr(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        kw(HP); word(w0); word(w1); word(w2); word(w3);
    endtask

    task automatic do_reset();
        @(negedge local_clk);
        reset = 1'b1;
        in_active = 1'b0;
        model_reset();
        @(negedge local_clk);
        reset = 1'b0;
        check("reset_hdr", hp_header, 96'h0);
        check("reset_rest", {hp_lcw, dpp_data, dpp_words, hp_valid, dpp_valid, dpp_start,
                             dpp_end, dpp_abort, err_frame}, 96'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(negedge local_clk);
        reset = 1'b0;
        check("reset_hdr", hp_header, 96'h0);
        check("reset_rest", {hp_lcw, dpp_data, dpp_words, hp_valid, dpp_valid, dpp_start,
                             dpp_end, dpp_abort, err_frame}, 96'h0);

        // basic header
        send_hdr(32'h11111111, 32'h22222222, 32'h33333333, 32'h4444ABCD);
        idle(1);
        check("t1_hp_valid", hp_valid, 1);
        check("t1_hp_header", hp_header, 96'h111111112222222233333333);
        check("t1_hp_lcw", hp_lcw, 32'h4444ABCD);
        check("t1_err", err_frame, 0);

        // header + two-word payload
        send_hdr(32'h11111111, 32'h22222222, 32'h33333333, 32'h4444ABCD);
        kw(DPS); word(32'hDEADBEEF); word(32'h01020304); kw(DPE);
        idle(1);
        check("t2_dpp_end", dpp_end, 1);
        check("t2_dpp_words", dpp_words, 2);

        // single-cycle gap is transparent, then a full gap timeout mid-payload
        send_hdr(32'h11111111, 32'h22222222, 32'h33333333, 32'h4444ABCD);
        kw(DPS); word(32'hDEADBEEF); idle(1); word(32'h01020304); kw(DPE);
        send_hdr(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
        kw(DPS); word(32'h12345678); idle(GAP_TIMEOUT); idle(1);
        check("t3_timeout", {err_frame, dpp_abort}, 2'b11);
        word(32'h55555555); kw(DPE); idle(2);

        // overlength payload
        send_hdr(32'h0, 32'h1, 32'h2, 32'h3);
        kw(DPS);
        for (int i = 0; i < MAX_DPP_WORDS + 1; i++) word(32'(i) ^ 32'hA5A50000);
        kw(DPE); idle(2);
        check("t4_words", dpp_words, 257);

        // partial K inside a header, then a clean header
        kw(HP); word(32'h11111111); drive(1'b1, 32'h00BC0000, 4'b0100);
        send_hdr(32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666);

        // empty payload, back-to-back headers, restart on HPSTART
        kw(DPS); kw(DPE);
        send_hdr(32'h1, 32'h2, 32'h3, 32'h4);
        send_hdr(32'h5, 32'h6, 32'h7, 32'h8);
        kw(HP); word(32'hEEEEEEEE); kw(HP); word(32'h1); word(32'h2); word(32'h3); word(32'h4);
        idle(2);

        // reset mid-header, then a header from IDLE
        kw(HP); word(32'hCAFECAFE); word(32'hBEEFBEEF);
        do_reset();
        send_hdr(32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 32'hF0F0F0F0);
        idle(1);
        check("t6_hp_header", hp_header, 96'h13579BDF2468ACE00F0F0F0F);

        // randomized packet streams
        for (int ep = 0; ep < 60; ep++) begin
            int kind, fill, len, term;
            kind = $urandom_range(0, 5);
            if (kind <= 3) begin
                kw(HP);
                for (int i = 0; i < 4; i++) begin maybe_gap(); word($urandom()); end
                fill = $urandom_range(0, 5);
                for (int i = 0; i < fill; i++) begin
                    if ($urandom_range(0, 1) == 0) word($urandom()); else noise();
                end
                kw(DPS);
                len = $urandom_range(0, 12);
                for (int i = 0; i < len; i++) begin maybe_gap(); word($urandom()); end
                term = $urandom_range(0, 6);
                case (term)
                    0, 1, 2: kw(DPE);
                    3:       kw(DPA);
                    4:       noise();
                    5:       kw(HP);
                    default: idle(GAP_TIMEOUT + $urandom_range(0, 2));
                endcase
            end else if (kind == 4) begin
                kw(HP);
                len = $urandom_range(0, 3);
                for (int i = 0; i < len; i++) word($urandom());
                if ($urandom_range(0, 1) == 0) idle(GAP_TIMEOUT); else noise();
            end else begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 2) == 0) word($urandom()); else noise();
                end
            end
            idle($urandom_range(0, 2));
        end

        idle(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
